int_ctrl: RTL and testbench

- Interrupt controller directly upstream of the CPU's 8-bit `interrupcion` input.
- Synchronises eight asynchronous peripheral request lines and edge-detects them into sticky pending latches.
- Applies a software mask and selects the highest-priority source.
- Drives one one-hot line to the CPU for a fixed hold time, then enforces a minimum idle gap. The CPU has no acknowledge, so delivery is self-timed.

---
 rtl/int_ctrl.sv | 131 +++++++++++++
 tb/tb_int_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller that feeds the CPU's one-hot `interrupcion` input.
// It synchronises and edge-detects eight request lines into sticky pending
// bits and masks them. It delivers the lowest-index eligible source for HOLD
// cycles and then holds the output low for GAP cycles. The CPU has no
// acknowledge, so the hold time and the gap are timed by the controller.
module int_ctrl #(
   parameter int                 N_IRQ      = 8,
   parameter int                 HOLD       = 2,
   parameter int                 GAP        = 4,
   parameter logic [N_IRQ-1:0]   MASK_RESET = 8'hFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_in,
   input  logic             clr_we,
   input  logic [N_IRQ-1:0] clr_in,
   output logic [N_IRQ-1:0] interrupcion,
   output logic [N_IRQ-1:0] pending,
   output logic             busy
);

   localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
   localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [N_IRQ-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] intr_q, intr_d;
   logic [N_IRQ-1:0] edge_det, eligible, winner, deliver_mask, clr_mask;

   // Synchroniser chain, edge detect and mask register next values
   always_comb begin
      s1_d     = irq_in;
      s2_d     = s1_q;
      s3_d     = s2_q;
      edge_det = s2_q & ~s3_q;
      mask_d   = mask_we ? mask_in : mask_q;
      clr_mask = clr_we ? clr_in : '0;
      eligible = pend_q & mask_q;
   end

   // Lowest-index eligible source wins; the loop runs downward so bit 0 is written last
   always_comb begin
      winner = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner    = '0;
            winner[i] = 1'b1;
         end
      end
   end

   // Delivery FSM: latch the winner in IDLE, hold it, then force a quiet gap
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      intr_d       = intr_q;
      deliver_mask = '0;
      case (state_q)
         S_IDLE: begin
            intr_d = '0;
            if (|eligible) begin
               intr_d       = winner;
               deliver_mask = winner;
               cnt_d        = HOLD_M1;
               state_d      = S_ASSERT;
            end
         end
         S_ASSERT: begin
            if (cnt_q == 8'd0) begin
               intr_d  = '0;
               cnt_d   = GAP_M1;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_GAP: begin
            intr_d = '0;
            if (cnt_q == 8'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            intr_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Pending latches: a fresh edge overrides both software clear and delivery clear
   always_comb begin
      pend_d = (pend_q & ~clr_mask & ~deliver_mask) | edge_det;
   end

   // State registers; reset drops the output and forgets all pending requests
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         pend_q  <= '0;
         mask_q  <= MASK_RESET;
         intr_q  <= '0;
         cnt_q   <= 8'd0;
         state_q <= S_IDLE;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         intr_q  <= intr_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign interrupcion = intr_q;
   assign pending      = pend_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with hand-computed expectations.
module tb_int_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_in;
   logic       clr_we;
   logic [7:0] clr_in;
   logic [7:0] interrupcion;
   logic [7:0] pending;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .irq_in       (irq_in),
      .mask_we      (mask_we),
      .mask_in      (mask_in),
      .clr_we       (clr_we),
      .clr_in       (clr_in),
      .interrupcion (interrupcion),
      .pending      (pending),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Wait for the next 0 -> nonzero transition of interrupcion; n counts negedges
   task automatic next_delivery(input int limit, output logic [7:0] v, output int n);
      logic seen_zero;
      seen_zero = (interrupcion == 8'h00);
      v = 8'h00;
      n = 0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (interrupcion == 8'h00) seen_zero = 1'b1;
         else if (seen_zero) begin
            v = interrupcion;
            return;
         end
      end
      n = -1;
   endtask

   task automatic count_deliveries(input int cycles, output int cnt);
      logic [7:0] prev;
      prev = interrupcion;
      cnt = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (prev == 8'h00 && interrupcion != 8'h00) cnt++;
         prev = interrupcion;
      end
   endtask

   task automatic write_mask(input logic [7:0] m);
      mask_in = m;
      mask_we = 1'b1;
      @(negedge clk);
      mask_we = 1'b0;
   endtask

   initial begin
      logic [7:0] v;
      int n;
      int cnt;

      reset = 1'b1; irq_in = 8'h00; mask_we = 1'b0; mask_in = 8'h00;
      clr_we = 1'b0; clr_in = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_intr", interrupcion, 8'h00);
      chk("rst_pend", pending, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'h00);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single pulse on line 3: latency and hold/gap timing
      irq_in = 8'h08;
      @(negedge clk); irq_in = 8'h00;          // after E1
      chk("t1_pend_e1", pending, 8'h00);
      @(negedge clk);                           // after E2
      chk("t1_pend_e2", pending, 8'h00);
      @(negedge clk);                           // after E3
      chk("t1_pend_e3", pending, 8'h08);
      chk("t1_intr_e3", interrupcion, 8'h00);
      @(negedge clk);                           // after E4
      chk("t1_intr_e4", interrupcion, 8'h08);
      chk("t1_pend_e4", pending, 8'h00);
      chk("t1_busy_e4", {7'b0, busy}, 8'h01);
      @(negedge clk);                           // after E5
      chk("t1_intr_e5", interrupcion, 8'h08);
      @(negedge clk);                           // after E6
      chk("t1_intr_e6", interrupcion, 8'h00);
      for (int i = 0; i < 4; i++) begin
         chk("t1_busy_gap", {7'b0, busy}, 8'h01);
         @(negedge clk);
      end
      chk("t1_busy_end", {7'b0, busy}, 8'h00);

      // Two sources at once: priority and back-to-back spacing
      irq_in = 8'h24;
      next_delivery(20, v, n);
      chk("t2_first", v, 8'h04);
      next_delivery(20, v, n);
      chk("t2_second", v, 8'h20);
      chk("t2_spacing", 8'(n), 8'd7);
      irq_in = 8'h00;
      repeat (10) @(negedge clk);

      // Masked source latches but is not delivered until unmasked
      write_mask(8'hFE);
      irq_in = 8'h01;
      @(negedge clk); irq_in = 8'h00;
      repeat (6) @(negedge clk);
      chk("t3_pend", pending, 8'h01);
      chk("t3_nodeliv", interrupcion, 8'h00);
      chk("t3_idle", {7'b0, busy}, 8'h00);
      write_mask(8'hFF);
      chk("t3_w_plus0", interrupcion, 8'h00);
      @(negedge clk);
      chk("t3_w_plus1", interrupcion, 8'h01);
      repeat (8) @(negedge clk);
      chk("t3_pend_end", pending, 8'h00);

      // Software clear of a masked pending bit, then clear colliding with an edge
      write_mask(8'hDF);
      irq_in = 8'h20;
      @(negedge clk); irq_in = 8'h00;          // after E1
      @(negedge clk);                           // after E2
      @(negedge clk);                           // after E3
      chk("t4_pend_set", pending, 8'h20);
      clr_we = 1'b1; clr_in = 8'h20;
      @(negedge clk); clr_we = 1'b0;
      chk("t4_pend_clr", pending, 8'h00);
      repeat (3) @(negedge clk);
      chk("t4_nodeliv", interrupcion, 8'h00);
      irq_in = 8'h20;
      @(negedge clk); irq_in = 8'h00;          // after E1
      @(negedge clk);                           // after E2: edge active now
      clr_we = 1'b1; clr_in = 8'h20;
      @(negedge clk); clr_we = 1'b0;           // after E3
      chk("t4_edge_wins", pending, 8'h20);
      clr_we = 1'b1;
      @(negedge clk); clr_we = 1'b0;
      chk("t4_pend_clr2", pending, 8'h00);
      write_mask(8'hFF);
      repeat (3) @(negedge clk);
      chk("t4_nodeliv2", interrupcion, 8'h00);

      // Held level delivers once; re-edge during ASSERT delivers again after GAP
      irq_in = 8'h02;
      count_deliveries(20, cnt);
      chk("t5_held_once", 8'(cnt), 8'd1);
      irq_in = 8'h00;
      repeat (3) @(negedge clk);
      irq_in = 8'h02;
      next_delivery(20, v, n);
      chk("t5_deliv", v, 8'h02);
      irq_in = 8'h00;
      @(negedge clk);
      irq_in = 8'h02;
      chk("t5_mid_hold", interrupcion, 8'h02);
      next_delivery(20, v, n);
      chk("t5_redeliv", v, 8'h02);
      chk("t5_redeliv_n", 8'(n), 8'd6);
      count_deliveries(20, cnt);
      chk("t5_no_more", 8'(cnt), 8'd0);
      irq_in = 8'h00;
      repeat (5) @(negedge clk);

      // Reset in the middle of ASSERT
      irq_in = 8'h10;
      @(negedge clk); irq_in = 8'h00;
      next_delivery(20, v, n);
      chk("t6_deliv", v, 8'h10);
      reset = 1'b1;
      #1;
      chk("t6_rst_intr", interrupcion, 8'h00);
      chk("t6_rst_pend", pending, 8'h00);
      chk("t6_rst_busy", {7'b0, busy}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      count_deliveries(15, cnt);
      chk("t6_no_deliv", 8'(cnt), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
